// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// Optional feature macro: FETCH_SKID_EN (one-entry skid buffer on the decode side).
package fetch_ctrl_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        u1  valid;
        u64 target;
    } redirect_t;

    localparam u64 FETCH_ALIGN_MASK = ~64'h3;

    function automatic u64 fetch_align(input u64 addr);
        return addr & FETCH_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-bus request/response and fetch-to-decode handshake bundle.
// master = fetch sequencer, slave = ibus + decode side.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    u1  ireq_valid;
    u64 ireq_addr;
    u1  ireq_ready;
    u1  iresp_valid;
    u32 iresp_data;
    u1  f_valid;
    u64 f_pc;
    u32 f_instr;
    u1  f_ready;

    modport master (
        output ireq_valid, ireq_addr,
        input  ireq_ready, iresp_valid, iresp_data,
        output f_valid, f_pc, f_instr,
        input  f_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output ireq_ready, iresp_valid, iresp_data,
        input  f_valid, f_pc, f_instr,
        output f_ready
    );

endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// Fixed-priority redirect select: trap entry beats mret beats branch/jump.
module redirect_arb
    import fetch_ctrl_pkg::*;
(
    input  u1         i_exception,
    input  u64        i_mtvec,
    input  u1         i_mret,
    input  u64        i_mepc,
    input  u1         i_jump,
    input  u64        i_pcjump,
    output redirect_t o_redirect
);

    always_comb begin
        o_redirect = '0;
        if (i_exception) begin
            o_redirect.valid  = 1'b1;
            o_redirect.target = fetch_align(i_mtvec);
        end else if (i_mret) begin
            o_redirect.valid  = 1'b1;
            o_redirect.target = fetch_align(i_mepc);
        end else if (i_jump) begin
            o_redirect.valid  = 1'b1;
            o_redirect.target = i_pcjump;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues one outstanding ibus request and
// hands words to decode. Define FETCH_SKID_EN for the skid-buffered 1-word/cycle variant.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter u64 RESET_PC = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  u1            i_exception,
    input  u64           i_mtvec,
    input  u1            i_mret,
    input  u64           i_mepc,
    input  u1            i_jump,
    input  u64           i_pcjump,
    fetch_ctrl_if.master bus
);

    fetch_state_t r_state, w_state_nxt;
    u64           r_pc, w_pc_nxt;
    u1            r_drop, w_drop_nxt;
    u1            r_f_valid, w_f_valid_nxt;
    u64           r_f_pc, w_f_pc_nxt;
    u32           r_f_instr, w_f_instr_nxt;
    u1            w_ireq_valid;
    u64           w_ireq_addr;
    redirect_t    w_rd;

    redirect_arb u_redirect_arb (
        .i_exception (i_exception),
        .i_mtvec     (i_mtvec),
        .i_mret      (i_mret),
        .i_mepc      (i_mepc),
        .i_jump      (i_jump),
        .i_pcjump    (i_pcjump),
        .o_redirect  (w_rd)
    );

`ifdef FETCH_SKID_EN
    u1  r_sk_valid, w_sk_valid_nxt;
    u64 r_sk_pc, w_sk_pc_nxt;
    u32 r_sk_instr, w_sk_instr_nxt;
    u1  w_f_acc;
    u1  w_room;

    assign w_f_acc = r_f_valid && bus.f_ready;
    // The skid is always empty while a request is outstanding, so f_* is the only slot to check.
    assign w_room  = !r_f_valid || w_f_acc;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_f_valid_nxt  = r_f_valid;
        w_f_pc_nxt     = r_f_pc;
        w_f_instr_nxt  = r_f_instr;
        w_sk_valid_nxt = r_sk_valid;
        w_sk_pc_nxt    = r_sk_pc;
        w_sk_instr_nxt = r_sk_instr;
        w_ireq_valid   = 1'b0;
        w_ireq_addr    = r_pc;

        if (w_f_acc) begin
            if (r_sk_valid) begin
                w_f_pc_nxt     = r_sk_pc;
                w_f_instr_nxt  = r_sk_instr;
                w_sk_valid_nxt = 1'b0;
            end else begin
                w_f_valid_nxt  = 1'b0;
            end
        end

        case (r_state)
            REQ: begin
                w_ireq_valid = rst_n && !r_sk_valid;
                if (w_rd.valid) w_pc_nxt = w_rd.target;
                if (w_ireq_valid && bus.ireq_ready) begin
                    w_state_nxt = WAIT;
                    w_drop_nxt  = w_rd.valid;
                end
            end
            WAIT: begin
                if (w_rd.valid) begin
                    w_pc_nxt = w_rd.target;
                    if (bus.iresp_valid) begin
                        w_state_nxt = REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (bus.iresp_valid && r_drop) begin
                    w_state_nxt = REQ;
                    w_drop_nxt  = 1'b0;
                end else if (bus.iresp_valid) begin
                    w_pc_nxt = r_pc + 64'd4;
                    if (w_room) begin
                        w_f_valid_nxt = 1'b1;
                        w_f_pc_nxt    = r_pc;
                        w_f_instr_nxt = bus.iresp_data;
                        // Chain the next request into the response cycle for 1 word/cycle.
                        w_ireq_valid  = 1'b1;
                        w_ireq_addr   = r_pc + 64'd4;
                        w_state_nxt   = bus.ireq_ready ? WAIT : REQ;
                    end else begin
                        w_sk_valid_nxt = 1'b1;
                        w_sk_pc_nxt    = r_pc;
                        w_sk_instr_nxt = bus.iresp_data;
                        w_state_nxt    = REQ;
                    end
                end
            end
            default: w_state_nxt = REQ;
        endcase

        if (w_rd.valid) begin
            w_f_valid_nxt  = 1'b0;
            w_sk_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sk_valid <= 1'b0;
            r_sk_pc    <= '0;
            r_sk_instr <= '0;
        end else begin
            r_sk_valid <= w_sk_valid_nxt;
            r_sk_pc    <= w_sk_pc_nxt;
            r_sk_instr <= w_sk_instr_nxt;
        end
    end
`else
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_drop_nxt    = r_drop;
        w_f_valid_nxt = r_f_valid;
        w_f_pc_nxt    = r_f_pc;
        w_f_instr_nxt = r_f_instr;
        w_ireq_valid  = 1'b0;
        w_ireq_addr   = r_pc;

        case (r_state)
            REQ: begin
                w_ireq_valid = rst_n;
                if (w_rd.valid) w_pc_nxt = w_rd.target;
                // A redirect racing the handshake leaves a stale request in flight.
                if (bus.ireq_ready) begin
                    w_state_nxt = WAIT;
                    w_drop_nxt  = w_rd.valid;
                end
            end
            WAIT: begin
                if (w_rd.valid) begin
                    w_pc_nxt = w_rd.target;
                    if (bus.iresp_valid) begin
                        w_state_nxt = REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (bus.iresp_valid && r_drop) begin
                    w_state_nxt = REQ;
                    w_drop_nxt  = 1'b0;
                end else if (bus.iresp_valid) begin
                    w_f_valid_nxt = 1'b1;
                    w_f_pc_nxt    = r_pc;
                    w_f_instr_nxt = bus.iresp_data;
                    w_pc_nxt      = r_pc + 64'd4;
                    w_state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (w_rd.valid) begin
                    w_f_valid_nxt = 1'b0;
                    w_pc_nxt      = w_rd.target;
                    w_state_nxt   = REQ;
                end else if (bus.f_ready) begin
                    w_f_valid_nxt = 1'b0;
                    w_state_nxt   = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= REQ;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_f_valid <= 1'b0;
            r_f_pc    <= '0;
            r_f_instr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_drop    <= w_drop_nxt;
            r_f_valid <= w_f_valid_nxt;
            r_f_pc    <= w_f_pc_nxt;
            r_f_instr <= w_f_instr_nxt;
        end
    end

    assign bus.ireq_valid = w_ireq_valid;
    assign bus.ireq_addr  = w_ireq_addr;
    assign bus.f_valid    = r_f_valid;
    assign bus.f_pc       = r_f_pc;
    assign bus.f_instr    = r_f_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized ibus/decode/redirect traffic
// checked against an instruction-stream model (next delivered PC, word = f(address)).
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    u1    exception, mret, jump;
    u64   mtvec, mepc, pcjump;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_exception (exception),
        .i_mtvec     (mtvec),
        .i_mret      (mret),
        .i_mepc      (mepc),
        .i_jump      (jump),
        .i_pcjump    (pcjump),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // staged redirect inputs, applied on the next cycle by cyc()
    logic        st_exc, st_mret, st_jmp;
    logic [63:0] st_mtvec, st_mepc, st_pcjump;
    // ibus / decode behaviour knobs
    int rdy_pct, frdy_pct, lat_min, lat_max;
    // reference model state
    logic [63:0] exp_pc;
    bit          os;
    logic [63:0] os_addr;
    int          lat;
    int          n_acc;
    // values sampled in the most recent cycle
    logic        s_ireq_valid, s_f_valid;
    logic [63:0] s_ireq_addr, s_f_pc;
    logic [31:0] s_f_instr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [63:0] a);
        return 32'h0000_0013 ^ a[31:0] ^ 32'h8000_0000;
    endfunction

    task automatic idle_inputs();
        exception = 1'b0; mret = 1'b0; jump = 1'b0;
        mtvec = '0; mepc = '0; pcjump = '0;
        st_exc = 1'b0; st_mret = 1'b0; st_jmp = 1'b0;
        bus.ireq_ready = 1'b0; bus.iresp_valid = 1'b0; bus.iresp_data = '0; bus.f_ready = 1'b0;
    endtask

    // One clock of traffic: drive after negedge, sample 1 unit later, advance the model.
    task automatic cyc();
        logic        rd;
        logic [63:0] tgt;
        @(negedge clk);
        exception = st_exc; mret = st_mret; jump = st_jmp;
        mtvec = st_mtvec; mepc = st_mepc; pcjump = st_pcjump;
        st_exc = 1'b0; st_mret = 1'b0; st_jmp = 1'b0;
        bus.iresp_valid = os && (lat == 0);
        bus.iresp_data  = bus.iresp_valid ? memw(os_addr) : 32'hDEAD_BEEF;
        bus.ireq_ready  = ($urandom_range(99) < rdy_pct);
        bus.f_ready     = ($urandom_range(99) < frdy_pct);
        #1;
        s_ireq_valid = bus.ireq_valid; s_ireq_addr = bus.ireq_addr;
        s_f_valid = bus.f_valid; s_f_pc = bus.f_pc; s_f_instr = bus.f_instr;
        rd  = exception | mret | jump;
        tgt = exception ? (mtvec & ~64'h3) : mret ? (mepc & ~64'h3) : pcjump;
        if (os && !bus.iresp_valid) chk("one_outstanding", 64'(bus.ireq_valid), 64'd0);
        if (bus.f_valid && bus.f_ready && !rd) begin
            chk("f_pc", bus.f_pc, exp_pc);
            chk("f_instr", 64'(bus.f_instr), 64'(memw(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            n_acc++;
        end
        if (rd) exp_pc = tgt;
        if (bus.iresp_valid) os = 1'b0;
        else if (os && lat > 0) lat--;
        if (bus.ireq_valid && bus.ireq_ready) begin
            os = 1'b1; os_addr = bus.ireq_addr; lat = $urandom_range(lat_max, lat_min);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ireq_valid"}, 64'(bus.ireq_valid), 64'd0);
        chk({tag, "_f_valid"}, 64'(bus.f_valid), 64'd0);
        chk({tag, "_ireq_addr"}, bus.ireq_addr, RST_PC);
        chk({tag, "_f_pc"}, bus.f_pc, 64'd0);
        chk({tag, "_f_instr"}, 64'(bus.f_instr), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        idle_inputs();
        st_mtvec = '0; st_mepc = '0; st_pcjump = '0;
        os = 1'b0; lat = 0; os_addr = '0; n_acc = 0; exp_pc = RST_PC;
        rdy_pct = 100; frdy_pct = 100; lat_min = 0; lat_max = 0;
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;

        // 1: zero-wait fetch from reset PC, 2-cycle request-to-f_valid latency
        cyc();
        chk("t1_req_v", 64'(s_ireq_valid), 64'd1);
        chk("t1_req_addr", s_ireq_addr, 64'h8000_0000);
        cyc();
        chk("t1_wait_fv", 64'(s_f_valid), 64'd0);
        cyc();
        chk("t1_fv", 64'(s_f_valid), 64'd1);
        chk("t1_f_pc", s_f_pc, 64'h8000_0000);
        chk("t1_f_instr", 64'(s_f_instr), 64'h13);
        cyc();
        chk("t1_next_addr", s_ireq_addr, 64'h8000_0004);

        // 2: exception and jump together; trap target wins, aligned
        rdy_pct = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (s_ireq_valid) break;
        end
        chk("t2_in_req", 64'(s_ireq_valid), 64'd1);
        st_exc = 1'b1; st_mtvec = 64'h8000_0103;
        st_jmp = 1'b1; st_pcjump = 64'h9000_0000;
        cyc();
        cyc();
        chk("t2_req_v", 64'(s_ireq_valid), 64'd1);
        chk("t2_addr", s_ireq_addr, 64'h8000_0100);

        // 3: jump while waiting for a response; stale word must be dropped
        rdy_pct = 100; lat_min = 2; lat_max = 2;
        cyc();
        rdy_pct = 0;
        st_jmp = 1'b1; st_pcjump = 64'h8000_0040;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            seen |= s_f_valid;
            if (s_ireq_valid) break;
        end
        chk("t3_no_fvalid", 64'(seen), 64'd0);
        chk("t3_reissue", 64'(s_ireq_valid), 64'd1);
        chk("t3_addr", s_ireq_addr, 64'h8000_0040);

        // 4: decode stalls; held word stays put
        rdy_pct = 100; lat_min = 0; lat_max = 0; frdy_pct = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (s_f_valid) break;
        end
        chk("t4_fv", 64'(s_f_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_hold_fv", 64'(s_f_valid), 64'd1);
            chk("t4_hold_pc", s_f_pc, 64'h8000_0040);
            chk("t4_hold_instr", 64'(s_f_instr), 64'(memw(64'h8000_0040)));
`ifndef FETCH_SKID_EN
            chk("t4_no_req", 64'(s_ireq_valid), 64'd0);
`endif
        end

        // 5: mret in HOLD with f_ready; held word squashed
        rdy_pct = 0; frdy_pct = 100;
        st_mret = 1'b1; st_mepc = 64'h8000_0206;
        cyc();
        cyc();
        chk("t5_fv", 64'(s_f_valid), 64'd0);
        chk("t5_req_v", 64'(s_ireq_valid), 64'd1);
        chk("t5_addr", s_ireq_addr, 64'h8000_0204);

        // 6: reset while waiting; late response after release is ignored
        rdy_pct = 100; lat_min = 3; lat_max = 3;
        cyc();
        cyc();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1 chk_reset_outputs("t6_rst");
        @(negedge clk) rst_n = 1'b1;
        lat = 0; rdy_pct = 0; exp_pc = RST_PC;
        cyc();
        chk("t6_late_addr", s_ireq_addr, RST_PC);
        cyc();
        chk("t6_fv", 64'(s_f_valid), 64'd0);
        chk("t6_req_v", 64'(s_ireq_valid), 64'd1);
        chk("t6_addr", s_ireq_addr, RST_PC);

        // randomized traffic with random redirects, including a jump near the 2^64 wrap
        lat_min = 0; lat_max = 3;
        for (int blk = 0; blk < 8; blk++) begin
            rdy_pct  = 30 + int'($urandom_range(70));
            frdy_pct = 30 + int'($urandom_range(70));
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(99) < 5) begin
                    st_exc    = ($urandom_range(2) == 0);
                    st_mret   = ($urandom_range(2) == 0);
                    st_jmp    = ($urandom_range(1) == 0);
                    st_mtvec  = 64'h8000_0000 + 64'($urandom_range(4095));
                    st_mepc   = 64'h8000_1000 + 64'($urandom_range(4095));
                    st_pcjump = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                              : 64'h8000_2000 + 64'($urandom_range(1023)) * 4;
                end
                cyc();
            end
        end
        chk("progress", 64'(n_acc > 200), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
